seq101_scan_sched: RTL and testbench
====================================

Name: seq101_scan_sched

Overview:
- Shares one "101" overlapping Mealy sequence detector among NREQ requesters.
- Each requester offers a WIDTH-bit word. A round-robin arbiter grants one requester at a time.
- The granted word is shifted MSB-first through the detector.
- Per word, the block reports the match count and a per-bit match mask with a done pulse. It sits between requester agents and the shared detector.

Parameters:
- NREQ, 4, number of requesters (2..8)
- WIDTH, 8, bits per word (3..32)
- CNT_W, 4, match count width; must hold floor((WIDTH-1)/2)
- ID_W, 2, requester id width; must equal clog2(NREQ)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset; one clock; all state clears immediately on assertion
- req  in  NREQ  per-requester request level; held high until gnt
- data  in  NREQ*WIDTH  word of requester i on data[i*WIDTH +: WIDTH]; sampled in the gnt cycle
- gnt  out  NREQ  one-hot, 1-cycle pulse; word captured this cycle
- busy  out  1  high from the gnt cycle through the done cycle
- done  out  1  1-cycle result pulse
- done_id  out  ID_W  index of requester whose result is presented
- match_cnt  out  CNT_W  detections in the word
- match_mask  out  WIDTH  bit b set if a "101" ends on word bit b

Behaviour:
- Reset values: gnt=0, busy=0, done=0, done_id=0, match_cnt=0, match_mask=0. FSM=IDLE, rr pointer last=NREQ-1 (req0 has first priority), detector at S0 with y=0.
- FSM states: IDLE, SHIFT, DRAIN, DONE.
- IDLE:
  - If any req bit is high, pick the first set bit searching from last+1 mod NREQ upward with wrap.
  - In that same cycle: gnt one-hot high, capture data into the shift register, and pulse the detector sync clear.
  - Also in that cycle: set last=winner, clear the bit counter, count and mask; go to SHIFT. busy is high from this cycle.
- SHIFT:
  - Cycle k (k=0..WIDTH-1) drives shreg MSB (word bit WIDTH-1-k) to detector x, then shifts left.
  - Detector y is registered, so y for bit k appears in cycle k+1.
  - When y=1, increment count and set mask bit WIDTH-k (the previous bit).
  - After k=WIDTH-1, go to DRAIN.
- DRAIN: capture y for the last bit (mask bit 0), then go to DONE.
- DONE:
  - done=1; done_id, match_cnt and match_mask are valid and hold until the next done.
  - Next state is IDLE. The next grant is possible in the following cycle.
- Latency: grant in cycle G, done in cycle G+WIDTH+2. Each word occupies WIDTH+3 cycles.
- Detector behaviour:
  - S0 --1--> S1, S0 --0--> S0.
  - S1 --1--> S1, S1 --0--> S2.
  - S2 --0--> S0, S2 --1--> S1 with y=1.
  - Overlap is allowed. y is registered and is 0 on every other transition.
  - Sync clr forces S0 and y=0 and has priority over x. Because of the clr, words never combine across boundaries.
- Requests:
  - req changes during busy are ignored until IDLE.
  - A req dropped before its gnt is never granted.
  - A requester whose req is still high after its done is re-arbitrated normally and is not starved (rr).
- Reset mid-word aborts the word: no done, outputs go to reset values.

Decomposition:
- Shared package seq101_pkg holds:
  - The FSM state encoding localparams (IDLE=2'd0, SHIFT=2'd1, DRAIN=2'd2, DONE=2'd3).
  - The detector state encoding (S0=2'b00, S1=2'b01, S2=2'b10).
- One sub-module: seq101_det (clk, rst_n, clr, x, y). This is the shared Mealy detector with async active-low reset and sync clear.

Test Plan:
- Reset with rst_n=0, then release; req0 with data0=8'b1010_0101 -> gnt=4'b0001 at G, done at G+10, done_id=0, match_cnt=2, match_mask=8'b0010_0001.
- Single word 8'b1010_1010 (overlap) -> match_cnt=3, match_mask=8'b0010_1010. Word 8'hFF -> match_cnt=0, mask=0.
- req=4'b1111 held continuously with distinct words -> grant order 0,1,2,3,0. Grants are exactly 11 cycles apart, and each done_id matches its data.
- Boundary check:
  - req1 word 8'b0000_0010 (no internal match), then req2 word 8'b1000_0000.
  - Expected: both match_cnt=0. The detector clear prevents a cross-word "101".
- Mid-word: assert rst_n=0 at G+4 -> no done; all outputs 0 immediately. After release, a pending req is granted with req0 having first priority.
- req3 pulsed for 1 cycle while busy, then dropped -> never granted. req2 raised during busy and held -> granted in the cycle after done.

Source files
------------

// File: rtl/seq101_pkg.sv
// Shared encodings for the "101" scan scheduler: controller states and
// detector states.
package seq101_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } fsm_e;

  typedef enum logic [1:0] {
    S0 = 2'b00,
    S1 = 2'b01,
    S2 = 2'b10
  } det_e;

endpackage

// File: rtl/seq101_det.sv
// Overlapping "101" Mealy detector with a registered output. A synchronous
// clear returns it to S0 so that words never combine across boundaries.
module seq101_det
  import seq101_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic x_i,
  output logic y_o
);

  det_e state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S0;
      y_o     <= 1'b0;
    end else if (clr_i) begin
      state_q <= S0;
      y_o     <= 1'b0;
    end else begin
      y_o <= 1'b0;
      unique case (state_q)
        S0: state_q <= x_i ? S1 : S0;
        S1: state_q <= x_i ? S1 : S2;
        S2: begin
          state_q <= x_i ? S1 : S0;
          y_o     <= x_i;
        end
        default: state_q <= S0;
      endcase
    end
  end

endmodule

// File: rtl/seq101_scan_sched.sv
// Round-robin scheduler that feeds one requester word at a time, MSB first,
// through the shared "101" detector and reports count and per-bit mask.
module seq101_scan_sched
  import seq101_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int CNT_W = 4,
  parameter int ID_W  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_i,
  input  logic [NREQ*WIDTH-1:0] data_i,
  output logic [NREQ-1:0]       gnt_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [ID_W-1:0]       done_id_o,
  output logic [CNT_W-1:0]      match_cnt_o,
  output logic [WIDTH-1:0]      match_mask_o
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  fsm_e             state_q;
  logic [ID_W-1:0]  last_q;
  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] mask_q;
  logic [BW-1:0]    bit_q;
  logic [CNT_W-1:0] cnt_q;

  logic [ID_W-1:0]  winner;
  logic [ID_W-1:0]  cand;
  logic             found;
  logic             start;
  logic             y;

  always_comb begin
    winner = '0;
    cand   = '0;
    found  = 1'b0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = ID_W'((int'(last_q) + i) % NREQ);
      if (!found && req_i[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // The grant is a same-cycle decision in IDLE; gating with rst_n keeps it
  // low while reset is held even if requests are pending.
  assign start  = rst_n && (state_q == IDLE) && found;
  assign gnt_o  = start ? (NREQ'(1) << winner) : '0;
  assign busy_o = start || (state_q != IDLE);

  seq101_det u_det (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (start),
    .x_i   (shreg_q[WIDTH-1]),
    .y_o   (y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_q       <= ID_W'(NREQ - 1);
      shreg_q      <= '0;
      mask_q       <= '0;
      bit_q        <= '0;
      cnt_q        <= '0;
      done_o       <= 1'b0;
      done_id_o    <= '0;
      match_cnt_o  <= '0;
      match_mask_o <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (found) begin
            shreg_q <= data_i[int'(winner)*WIDTH +: WIDTH];
            last_q  <= winner;
            bit_q   <= '0;
            cnt_q   <= '0;
            mask_q  <= '0;
            state_q <= SHIFT;
          end
        end
        // y lags x by one cycle, so the mask shifts in from bit 1 onward and
        // once more in DRAIN; after WIDTH shifts bit b lines up with word bit b.
        SHIFT: begin
          shreg_q <= shreg_q << 1;
          bit_q   <= bit_q + 1'b1;
          cnt_q   <= cnt_q + CNT_W'(y);
          if (bit_q != '0) begin
            mask_q <= {mask_q[WIDTH-2:0], y};
          end
          if (bit_q == BW'(WIDTH - 1)) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          match_mask_o <= {mask_q[WIDTH-2:0], y};
          match_cnt_o  <= cnt_q + CNT_W'(y);
          done_id_o    <= last_q;
          done_o       <= 1'b1;
          state_q      <= DONE;
        end
        DONE: begin
          done_o  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq101_scan_sched.sv
// Directed bench for seq101_scan_sched: a table of single-word vectors plus
// hand-written round-robin, mid-word reset and busy-time request sequences.
module tb_seq101_scan_sched;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int CNT_W = 4;
  localparam int ID_W  = 2;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] data;
  logic [NREQ-1:0]       gnt;
  logic                  busy;
  logic                  done;
  logic [ID_W-1:0]       doneId;
  logic [CNT_W-1:0]      matchCnt;
  logic [WIDTH-1:0]      matchMask;

  int applied     = 0;
  int miscompares = 0;

  typedef struct {
    logic [1:0] id;
    logic [7:0] word;
    logic [3:0] cnt;
    logic [7:0] mask;
  } vec_t;

  vec_t vecs[9];

  seq101_scan_sched #(
    .NREQ  (NREQ),
    .WIDTH (WIDTH),
    .CNT_W (CNT_W),
    .ID_W  (ID_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_i        (req),
    .data_i       (data),
    .gnt_o        (gnt),
    .busy_o       (busy),
    .done_o       (done),
    .done_id_o    (doneId),
    .match_cnt_o  (matchCnt),
    .match_mask_o (matchMask)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] r, input int id, input logic [7:0] w);
    data[id*WIDTH +: WIDTH] = w;
    req = r;
  endtask

  // Waits (bounded) for a grant and checks it; returns at the negedge of G.
  task automatic awaitGrant(input string name, input logic [3:0] expGnt);
    int n;
    n = 0;
    @(negedge clk);
    while (gnt === 4'b0000 && n < 30) begin
      @(posedge clk); #1;
      @(negedge clk);
      n++;
    end
    checkOutput(name, 32'(gnt), 32'(expGnt));
    checkOutput({name, "Busy"}, 32'(busy), 32'd1);
  endtask

  // Starting at the negedge of G, expects done exactly in cycle G+WIDTH+2.
  task automatic trackDone(input string name, input logic [1:0] id, input logic [3:0] cnt,
                           input logic [7:0] mask, input logic [3:0] reqAfter,
                           input logic [3:0] reqLater);
    int early;
    early = 0;
    for (int n = 1; n <= WIDTH + 1; n++) begin
      @(posedge clk); #1;
      if (n == 1) req = reqAfter;
      if (n == 2) req = reqLater;
      @(negedge clk);
      if (done !== 1'b0) early++;
    end
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput({name, "Early"}, 32'(early), 32'd0);
    checkOutput({name, "Done"}, 32'(done), 32'd1);
    checkOutput({name, "Id"}, 32'(doneId), 32'(id));
    checkOutput({name, "Cnt"}, 32'(matchCnt), 32'(cnt));
    checkOutput({name, "Mask"}, 32'(matchMask), 32'(mask));
  endtask

  initial begin
    logic [1:0] order[5];
    logic [3:0] rrCnt[4];
    logic [7:0] rrMask[4];
    int cyc, lastG, g, d, stray;

    rst_n = 1'b0;
    req   = '0;
    data  = 32'hDEAD_BEEF;

    vecs[0] = '{2'd0, 8'b1010_0101, 4'd2, 8'b0010_0001};
    vecs[1] = '{2'd1, 8'b1010_1010, 4'd3, 8'b0010_1010};
    vecs[2] = '{2'd2, 8'hFF,        4'd0, 8'h00};
    vecs[3] = '{2'd3, 8'b1011_0101, 4'd3, 8'b0010_0101};
    vecs[4] = '{2'd0, 8'b0101_0101, 4'd3, 8'b0001_0101};
    vecs[5] = '{2'd1, 8'h00,        4'd0, 8'h00};
    vecs[6] = '{2'd2, 8'b1001_0100, 4'd1, 8'b0000_0100};
    vecs[7] = '{2'd1, 8'b0000_0010, 4'd0, 8'h00};
    vecs[8] = '{2'd2, 8'b1000_0000, 4'd0, 8'h00};

    @(negedge clk);
    checkOutput("rstGnt", 32'(gnt), 32'd0);
    checkOutput("rstBusy", 32'(busy), 32'd0);
    checkOutput("rstDone", 32'(done), 32'd0);
    checkOutput("rstId", 32'(doneId), 32'd0);
    checkOutput("rstCnt", 32'(matchCnt), 32'd0);
    checkOutput("rstMask", 32'(matchMask), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      applyStimulus(4'b0001 << vecs[i].id, int'(vecs[i].id), vecs[i].word);
      awaitGrant("vecGnt", 4'b0001 << vecs[i].id);
      trackDone("vec", vecs[i].id, vecs[i].cnt, vecs[i].mask, 4'b0000, 4'b0000);
      @(posedge clk); #1;
    end

    // Round robin with all requests held, starting from a fresh pointer.
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    data   = {8'b1011_0101, 8'hFF, 8'b1010_1010, 8'b1010_0101};
    rrCnt  = '{4'd2, 4'd3, 4'd0, 4'd3};
    rrMask = '{8'h21, 8'h2A, 8'h00, 8'h25};
    order  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    req    = 4'b1111;
    cyc = 0; lastG = 0; g = 0; d = 0;
    while (cyc < 80) begin
      @(negedge clk);
      if (gnt !== 4'b0000) begin
        checkOutput("rrGnt", 32'(gnt), 32'(4'b0001 << order[g]));
        if (g > 0) checkOutput("rrGap", 32'(cyc - lastG), 32'd11);
        lastG = cyc;
        g++;
      end
      if (done === 1'b1 && d < 4) begin
        checkOutput("rrDoneId", 32'(doneId), 32'(order[d]));
        checkOutput("rrCnt", 32'(matchCnt), 32'(rrCnt[order[d]]));
        checkOutput("rrMask", 32'(matchMask), 32'(rrMask[order[d]]));
        d++;
      end
      if (g == 5) break;
      @(posedge clk); #1;
      cyc++;
    end
    checkOutput("rrGrants", 32'(g), 32'd5);
    checkOutput("rrDones", 32'(d), 32'd4);

    // Abort the in-flight word at G+4 with requests 0 and 1 pending.
    @(posedge clk); #1;
    req = 4'b0011;
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    checkOutput("abortGnt", 32'(gnt), 32'd0);
    checkOutput("abortBusy", 32'(busy), 32'd0);
    checkOutput("abortDone", 32'(done), 32'd0);
    checkOutput("abortId", 32'(doneId), 32'd0);
    checkOutput("abortCnt", 32'(matchCnt), 32'd0);
    checkOutput("abortMask", 32'(matchMask), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    awaitGrant("postRstGnt", 4'b0001);
    trackDone("postRst", 2'd0, 4'd2, 8'h21, 4'b0000, 4'b0000);

    // req3 pulsed during busy, req2 raised and held during busy.
    @(posedge clk); #1;
    applyStimulus(4'b0001, 0, 8'b1010_1010);
    awaitGrant("plsGnt", 4'b0001);
    trackDone("pls", 2'd0, 4'd3, 8'h2A, 4'b1000, 4'b0100);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("req2NextGnt", 32'(gnt), 32'(4'b0100));
    checkOutput("req2DoneLow", 32'(done), 32'd0);
    trackDone("req2", 2'd2, 4'd0, 8'h00, 4'b0000, 4'b0000);
    stray = 0;
    repeat (15) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (gnt !== 4'b0000 || busy !== 1'b0) stray++;
    end
    checkOutput("req3Never", 32'(stray), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
